// File: rtl/axi_burst_master_if.sv
// AXI4 initiator-side bus bundle for axi_burst_master: AW, W, B, AR and R channels.
interface axi_burst_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst initiator: command port in, write/read beat streams,
// worst-case response reported on a done handshake.
module axi_burst_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,

    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,

    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,

    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [1:0]            done_resp,

    axi_burst_master_if.master    m_axi
);
    localparam int unsigned SIZE_W = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << SIZE_W) - 64'd1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3;
    localparam logic [2:0] S_RADDR = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]            resp_acc_q, resp_acc_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  done_valid_q, done_valid_d;
    logic [1:0]            done_resp_q, done_resp_d;
    logic                  beat_last;
    logic [1:0]            beat_resp;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign beat_last = (cnt_q == len_q);

    // Address channels: fields come straight from the latched command.
    assign m_axi.awid    = id_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = 3'(SIZE_W);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.arid    = id_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = 3'(SIZE_W);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.wdata = wr_data;
    assign m_axi.wstrb = wr_strb;
    assign rd_data     = m_axi.rdata;

    assign cmd_ready  = cmd_ready_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        resp_acc_d   = resp_acc_q;
        beat_resp    = resp_acc_q;
        wr_ready     = 1'b0;
        m_axi.wvalid = 1'b0;
        m_axi.wlast  = 1'b0;
        m_axi.bready = 1'b0;
        m_axi.rready = 1'b0;
        rd_valid     = 1'b0;
        rd_last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d     = cmd_addr & ALIGN_MASK;
                    len_d      = cmd_len;
                    id_d       = cmd_id;
                    cnt_d      = 8'd0;
                    resp_acc_d = 2'b00;
                    state_d    = cmd_write ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                if (m_axi.awready) state_d = S_WDATA;
            end
            S_WDATA: begin
                m_axi.wvalid = wr_valid;
                wr_ready     = m_axi.wready;
                m_axi.wlast  = beat_last;
                if (wr_valid && m_axi.wready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (beat_last) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    beat_resp = worst(resp_acc_q, m_axi.bresp);
                    if (m_axi.bid != id_q) beat_resp = worst(beat_resp, RESP_SLVERR);
                    resp_acc_d = beat_resp;
                    state_d    = S_DONE;
                end
            end
            S_RADDR: begin
                if (m_axi.arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                rd_valid     = m_axi.rvalid;
                m_axi.rready = rd_ready;
                rd_last      = beat_last;
                if (m_axi.rvalid && rd_ready) begin
                    // ID or burst-length disagreement from the subordinate is reported as SLVERR.
                    beat_resp = worst(resp_acc_q, m_axi.rresp);
                    if ((m_axi.rid != id_q) || (m_axi.rlast != beat_last))
                        beat_resp = worst(beat_resp, RESP_SLVERR);
                    resp_acc_d = beat_resp;
                    cnt_d      = cnt_q + 8'd1;
                    if (beat_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        awvalid_d    = (state_d == S_WADDR);
        arvalid_d    = (state_d == S_RADDR);
        done_valid_d = (state_d == S_DONE);
        done_resp_d  = done_valid_d ? resp_acc_d : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            id_q         <= '0;
            resp_acc_q   <= 2'b00;
            cmd_ready_q  <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            resp_acc_q   <= resp_acc_d;
            cmd_ready_q  <= cmd_ready_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI RAM subordinate plus scoreboard queues for
// read beats and completion responses.
module tb_axi_burst_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 8;
    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [IW-1:0] cmd_id = '0;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last, rd_valid, rd_ready;
    logic          done_valid, done_ready;
    logic [1:0]    done_resp;

    axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
        .m_axi(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {last, data} per read beat, and one response per command.
    logic [32:0] rd_q[$];
    logic [1:0]  done_q[$];
    logic [31:0] refmem [0:1023];

    // Subordinate controls and observation
    logic [1:0]  inj_bresp = 2'b00, inj_rresp = 2'b00;
    logic        bad_bid = 1'b0;
    logic        rd_toggle = 1'b0, hold_done = 1'b0;
    int unsigned w_beats, w_lasts;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [7:0]  last_arlen;
    logic [2:0]  last_arsize;

    // Behavioural AXI RAM subordinate with random ready/valid gaps
    logic [31:0]   smem [0:1023];
    logic          w_act, r_act;
    logic [AW-1:0] w_addr, r_addr;
    logic [7:0]    r_len;
    logic [IW-1:0] w_id, r_id;
    logic [8:0]    w_idx, r_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0;
            bus.bid <= '0; bus.bresp <= 2'b00; bus.arready <= 1'b0;
            bus.rvalid <= 1'b0; bus.rlast <= 1'b0; bus.rdata <= '0;
            bus.rid <= '0; bus.rresp <= 2'b00;
            w_act <= 1'b0; r_act <= 1'b0; w_idx <= '0; r_idx <= '0;
            w_addr <= '0; r_addr <= '0; r_len <= '0; w_id <= '0; r_id <= '0;
            w_beats <= 0; w_lasts <= 0;
            last_awaddr <= '0; last_araddr <= '0; last_arlen <= '0; last_arsize <= '0;
        end else begin
            bus.awready <= !w_act && ($urandom_range(0, 1) == 1);
            if (bus.awvalid && bus.awready) begin
                w_act <= 1'b1; w_addr <= bus.awaddr; w_id <= bus.awid; w_idx <= '0;
                last_awaddr <= bus.awaddr;
            end
            bus.wready <= w_act && ($urandom_range(0, 3) != 0);
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (bus.wvalid && bus.wready) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wstrb[b]) smem[10'(w_addr >> 2) + 10'(w_idx)][8*b +: 8] <= bus.wdata[8*b +: 8];
                w_idx   <= w_idx + 9'd1;
                w_beats <= w_beats + 1;
                if (bus.wlast) begin
                    w_lasts    <= w_lasts + 1;
                    w_act      <= 1'b0;
                    bus.bvalid <= 1'b1;
                    bus.bid    <= bad_bid ? ~w_id : w_id;
                    bus.bresp  <= inj_bresp;
                end
            end

            bus.arready <= !r_act && !(bus.arvalid && bus.arready) && ($urandom_range(0, 1) == 1);
            if (bus.arvalid && bus.arready) begin
                r_act <= 1'b1; r_addr <= bus.araddr; r_len <= bus.arlen; r_id <= bus.arid; r_idx <= '0;
                last_araddr <= bus.araddr; last_arlen <= bus.arlen; last_arsize <= bus.arsize;
            end
            if (r_act && (!bus.rvalid || bus.rready)) begin
                if (bus.rvalid && bus.rlast) begin
                    bus.rvalid <= 1'b0; bus.rlast <= 1'b0; r_act <= 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= smem[10'(r_addr >> 2) + 10'(r_idx)];
                    bus.rlast  <= (r_idx == {1'b0, r_len});
                    bus.rid    <= r_id;
                    bus.rresp  <= inj_rresp;
                    r_idx      <= r_idx + 9'd1;
                end else begin
                    bus.rvalid <= 1'b0;
                end
            end
        end
    end

    // Consumer-side ready drivers
    initial begin
        rd_ready = 1'b1;
        done_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rd_ready   = rd_toggle ? !rd_ready : 1'b1;
            done_ready = !hold_done;
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid && rd_ready) begin
                if (rd_q.size() == 0) check_val("rd_unexpected_beat", 64'd1, 64'd0);
                else begin
                    logic [32:0] e;
                    e = rd_q.pop_front();
                    check_val("rd_data", 64'(rd_data), 64'(e[31:0]));
                    check_val("rd_last", 64'(rd_last), 64'(e[32]));
                end
            end
            if (done_valid && done_ready) begin
                if (done_q.size() == 0) check_val("done_unexpected", 64'd1, 64'd0);
                else check_val("done_resp", 64'(done_resp), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [IW-1:0] id, input logic [1:0] exp, input bit push_done);
        logic [AW-1:0] al;
        logic ok;
        int n;
        al = a & 16'hFFFC;
        if (!w)
            for (int i = 0; i <= int'(l); i++)
                rd_q.push_back({(i == int'(l)), refmem[10'(al >> 2) + 10'(i)]});
        if (push_done) done_q.push_back(exp);
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        check_val("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_beats(input logic [AW-1:0] a, input int nb, input logic [31:0] base,
                              input logic [3:0] strb, input bit gaps);
        logic [AW-1:0] al;
        logic ok;
        int n;
        logic [31:0] d;
        logic [9:0] idx;
        al = a & 16'hFFFC;
        for (int i = 0; i < nb; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            d = base + 32'(i);
            wr_data = d; wr_strb = strb; wr_valid = 1'b1;
            ok = 1'b0; n = 0;
            while (!ok && n < 200) begin
                @(negedge clk); ok = wr_ready;
                @(posedge clk); #1; n++;
            end
            wr_valid = 1'b0;
            check_val("wr_accept", 64'(ok), 64'd1);
            idx = 10'(al >> 2) + 10'(i);
            for (int b = 0; b < 4; b++) if (strb[b]) refmem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
            @(posedge clk); n++;
        end
        check_val("drain_in_time", 64'(n < 2000), 64'd1);
        #1;
    endtask

    initial begin
        int unsigned wb0, wl0;
        logic ok;
        #3;
        check_val("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_val("rst_outputs", 64'({bus.awvalid, bus.arvalid, bus.wvalid, bus.bready, bus.rready,
                  wr_ready, rd_valid, done_valid, done_resp}), 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // single-beat write, then read back
        wb0 = w_beats; wl0 = w_lasts;
        issue(1'b1, 16'h0010, 8'd0, 8'h11, 2'b00, 1'b1);
        send_beats(16'h0010, 1, 32'hDEADBEEF, 4'hF, 1'b0);
        wait_idle();
        check_val("t1_ram_word4", 64'(smem[4]), 64'hDEADBEEF);
        check_val("t1_w_beats", 64'(w_beats - wb0), 64'd1);
        check_val("t1_wlast", 64'(w_lasts - wl0), 64'd1);
        issue(1'b0, 16'h0010, 8'd0, 8'h22, 2'b00, 1'b1);
        wait_idle();
        check_val("t2_arlen", 64'(last_arlen), 64'd0);
        check_val("t2_arsize", 64'(last_arsize), 64'd2);
        check_val("t2_araddr", 64'(last_araddr), 64'h0010);

        // 4-beat burst with wr_valid gaps, read back with rd_ready toggling
        wb0 = w_beats; wl0 = w_lasts;
        issue(1'b1, 16'h0100, 8'd3, 8'h33, 2'b00, 1'b1);
        send_beats(16'h0100, 4, 32'd1, 4'hF, 1'b1);
        wait_idle();
        check_val("t3_w_beats", 64'(w_beats - wb0), 64'd4);
        check_val("t3_wlast", 64'(w_lasts - wl0), 64'd1);
        rd_toggle = 1'b1;
        issue(1'b0, 16'h0100, 8'd3, 8'h34, 2'b00, 1'b1);
        wait_idle();
        rd_toggle = 1'b0;
        check_val("t3_arlen", 64'(last_arlen), 64'd3);

        // unaligned address is forced to the word boundary; partial strobes merge
        issue(1'b1, 16'h0200, 8'd1, 8'h40, 2'b00, 1'b1);
        send_beats(16'h0200, 2, 32'h11111111, 4'hF, 1'b0);
        wait_idle();
        issue(1'b1, 16'h0203, 8'd1, 8'h41, 2'b00, 1'b1);
        send_beats(16'h0203, 2, 32'hA5A50000, 4'b0101, 1'b1);
        wait_idle();
        check_val("awaddr_aligned", 64'(last_awaddr), 64'h0200);
        issue(1'b0, 16'h0202, 8'd1, 8'h42, 2'b00, 1'b1);
        wait_idle();
        check_val("araddr_aligned", 64'(last_araddr), 64'h0200);

        // error responses: SLVERR, wrong BID, DECERR on reads; normal command afterwards
        inj_bresp = 2'b10;
        issue(1'b1, 16'h0010, 8'd0, 8'h50, 2'b10, 1'b1);
        send_beats(16'h0010, 1, 32'hCAFE0001, 4'hF, 1'b0);
        wait_idle();
        inj_bresp = 2'b00; bad_bid = 1'b1;
        issue(1'b1, 16'h0014, 8'd0, 8'h51, 2'b10, 1'b1);
        send_beats(16'h0014, 1, 32'hCAFE0002, 4'hF, 1'b0);
        wait_idle();
        bad_bid = 1'b0;
        issue(1'b0, 16'h0010, 8'd1, 8'h52, 2'b00, 1'b1);
        wait_idle();
        inj_rresp = 2'b11;
        issue(1'b0, 16'h0100, 8'd1, 8'h53, 2'b11, 1'b1);
        wait_idle();
        inj_rresp = 2'b00;

        // completion held off by done_ready
        hold_done = 1'b1;
        issue(1'b1, 16'h0020, 8'd0, 8'h60, 2'b00, 1'b1);
        send_beats(16'h0020, 1, 32'h12345678, 4'hF, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin @(negedge clk); ok = done_valid; end
        check_val("t5_done_seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check_val("t5_done_held", 64'(done_valid), 64'd1);
            check_val("t5_cmd_ready_low", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        hold_done = 1'b0;
        wait_idle();
        @(posedge clk); @(negedge clk);
        check_val("t5_cmd_ready_back", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // reset in the middle of a write burst
        issue(1'b1, 16'h0300, 8'd3, 8'h70, 2'b00, 1'b0);
        send_beats(16'h0300, 1, 32'h0BAD0300, 4'hF, 1'b0);
        wr_valid = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_outputs_in_rst", 64'({bus.awvalid, bus.arvalid, bus.wvalid, bus.bready,
                  bus.rready, cmd_ready, wr_ready, rd_valid, done_valid, done_resp}), 64'd0);
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        check_val("t6_no_valids", 64'({bus.awvalid, bus.wvalid, done_valid}), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 16'h0300, 8'd0, 8'h71, 2'b00, 1'b1);
        wait_idle();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
